// File: rtl/positdiv_iter.sv
// -----------------------------------------------------------------------------
// positdiv_iter
// Iterative posit<32,2> divider: result = in1 / in2.
// Operands are decoded when start is accepted. The 28-bit mantissas are then
// divided by a radix-2 restoring loop that produces one quotient bit per clock.
// One normalisation cycle follows, and an output cycle re-encodes the quotient
// with round-to-nearest-even. Latency is fixed: done pulses on the 33rd rising
// edge after the edge that accepted start, for every operand pair.
//
// Ports
//   clk      : clock
//   reset_n  : asynchronous active-low reset; aborts any operation in flight
//   start    : request, sampled only while idle
//   in1      : dividend posit
//   in2      : divisor posit
//   busy     : high from the cycle after start is accepted through normalisation
//   result   : quotient posit, held until the next operation completes
//   inf      : result is NaR (held with result)
//   zero     : result is zero (held with result)
//   done     : one-cycle pulse when result/inf/zero become valid
//
// Only NBITS=32, ES=2, QBITS=31 are supported.
// -----------------------------------------------------------------------------
module positdiv_iter #(
    parameter int NBITS = 32,
    parameter int ES    = 2,
    parameter int QBITS = 31
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [NBITS-1:0] in1,
    input  logic [NBITS-1:0] in2,
    output logic             busy,
    output logic [NBITS-1:0] result,
    output logic             inf,
    output logic             zero,
    output logic             done
);

    localparam int MBITS = NBITS - ES - 2;    // hidden one + 27 fraction bits
    localparam int RBITS = MBITS + 2;         // partial remainder width
    localparam int CW    = $clog2(QBITS);
    localparam logic [NBITS-1:0] NAR = {1'b1, {(NBITS-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIV, NORM, OUT} state_t;
    typedef enum logic [1:0] {SP_NONE, SP_NAR, SP_ZERO} special_t;

    typedef struct packed {
        logic             sign;
        logic [9:0]       scale;   // two's complement, 4*k + e
        logic [MBITS-1:0] mant;    // {1, fraction}
    } dec_t;

    // Split a posit into sign, scale and normalised mantissa.
    function automatic dec_t decode(input logic [NBITS-1:0] p);
        logic [NBITS-2:0] body;
        logic [NBITS-2:0] inv;
        logic [5:0]       run;
        logic [NBITS-4:0] rest;
        logic [9:0]       k;
        dec_t             d;
        body = p[NBITS-1] ? ((~p[NBITS-2:0]) + (NBITS-1)'(1)) : p[NBITS-2:0];
        // The regime run length is the leading-zero count once the run
        // is forced to zeros.
        inv = body[NBITS-2] ? ~body : body;
        run = 6'(NBITS - 1);
        for (int i = 0; i < NBITS - 1; i++) begin
            if (inv[i]) begin
                run = 6'(NBITS - 2 - i);
            end
        end
        // The regime plus its terminator take at least two bits. Shift the
        // remaining bits up by (run - 1) to left-align the exponent.
        rest    = body[NBITS-4:0] << (run - 6'd1);
        k       = body[NBITS-2] ? (10'(run) - 10'd1) : (10'd0 - 10'(run));
        d.sign  = p[NBITS-1];
        d.scale = (k << ES) + 10'(rest[NBITS-4 -: ES]);
        d.mant  = {1'b1, rest[NBITS-4-ES:0]};
        return d;
    endfunction

    // Build regime/exponent/fraction, truncate, and round to nearest even.
    function automatic logic [NBITS-1:0] encode(input logic             sgn,
                                                input logic [9:0]       scale,
                                                input logic [QBITS-2:0] frac,
                                                input logic             sticky);
        logic [5:0]       sh;
        logic [63:0]      base;
        logic [63:0]      s;
        logic [NBITS-2:0] mag;
        logic [NBITS-1:0] sum;
        logic             guard;
        logic             st;
        // Start from "10" (k >= 0) or "01" (k < 0). An arithmetic shift right by
        // k (or -k-1) replicates the leading bit into the full regime run.
        sh    = scale[9] ? ~scale[7:2] : scale[7:2];
        base  = {(scale[9] ? 2'b01 : 2'b10), scale[1:0], frac, 30'd0};
        s     = $signed(base) >>> sh;
        mag   = s[63:33];
        guard = s[32];
        st    = sticky | (|s[31:0]);
        sum   = {1'b0, mag} + {31'd0, guard & (st | mag[0])};
        // A carry out of the magnitude would alias NaR; clamp to maxpos.
        if (sum[NBITS-1]) begin
            mag = {(NBITS-1){1'b1}};
        end else begin
            mag = sum[NBITS-2:0];
        end
        if ($signed(scale) > 10'sd120) begin
            mag = {(NBITS-1){1'b1}};
        end else if ($signed(scale) < -10'sd120) begin
            mag = (NBITS-1)'(1);
        end
        return sgn ? ((~{1'b0, mag}) + 32'd1) : {1'b0, mag};
    endfunction

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [RBITS-1:0] rem_reg;
    logic [MBITS-1:0] mb_reg;
    logic [QBITS-1:0] q_reg;
    logic [9:0]       scale_reg;
    logic             sign_reg;
    special_t         special_reg;
    logic             sticky_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [NBITS-1:0] result_reg;
    logic             inf_reg;
    logic             zero_reg;

    dec_t             dec_a;
    dec_t             dec_b;
    special_t         special_next;
    logic             ge;
    logic [RBITS-2:0] rem_sub;
    logic [RBITS-1:0] rem_next;
    logic [NBITS-1:0] enc_result;

    always_comb begin
        dec_a = decode(in1);
        dec_b = decode(in2);

        // NaR operands win, then division by zero, then zero dividend.
        special_next = SP_NONE;
        if (in1 == NAR || in2 == NAR || in2 == '0) begin
            special_next = SP_NAR;
        end else if (in1 == '0) begin
            special_next = SP_ZERO;
        end

        // The remainder always stays below 2*mB, so bit RBITS-1 can be
        // dropped from the difference.
        ge       = rem_reg >= {2'b00, mb_reg};
        rem_sub  = rem_reg[RBITS-2:0] - {1'b0, mb_reg};
        rem_next = ge ? {rem_sub, 1'b0} : {rem_reg[RBITS-2:0], 1'b0};

        enc_result = encode(sign_reg, scale_reg, q_reg[QBITS-2:0], sticky_reg);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            rem_reg     <= '0;
            mb_reg      <= '0;
            q_reg       <= '0;
            scale_reg   <= '0;
            sign_reg    <= 1'b0;
            special_reg <= SP_NONE;
            sticky_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            result_reg  <= '0;
            inf_reg     <= 1'b0;
            zero_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        rem_reg     <= {2'b00, dec_a.mant};
                        mb_reg      <= dec_b.mant;
                        q_reg       <= '0;
                        cnt_reg     <= '0;
                        scale_reg   <= dec_a.scale - dec_b.scale;
                        sign_reg    <= dec_a.sign ^ dec_b.sign;
                        special_reg <= special_next;
                        busy_reg    <= 1'b1;
                        state_reg   <= DIV;
                    end
                end
                DIV: begin
                    rem_reg <= rem_next;
                    q_reg   <= {q_reg[QBITS-2:0], ge};
                    if (cnt_reg == CW'(QBITS - 1)) begin
                        state_reg <= NORM;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                NORM: begin
                    // mA < mB leaves the quotient in [1/2, 1): shift it up one.
                    if (!q_reg[QBITS-1]) begin
                        q_reg     <= q_reg << 1;
                        scale_reg <= scale_reg - 10'd1;
                    end
                    sticky_reg <= |rem_reg;
                    busy_reg   <= 1'b0;
                    state_reg  <= OUT;
                end
                OUT: begin
                    case (special_reg)
                        SP_NAR: begin
                            result_reg <= NAR;
                            inf_reg    <= 1'b1;
                            zero_reg   <= 1'b0;
                        end
                        SP_ZERO: begin
                            result_reg <= '0;
                            inf_reg    <= 1'b0;
                            zero_reg   <= 1'b1;
                        end
                        default: begin
                            result_reg <= enc_result;
                            inf_reg    <= 1'b0;
                            zero_reg   <= 1'b0;
                        end
                    endcase
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;
    assign inf    = inf_reg;
    assign zero   = zero_reg;

endmodule

// File: tb/tb_positdiv_iter.sv
// -----------------------------------------------------------------------------
// tb_positdiv_iter
// Directed and random checks for positdiv_iter. Each accepted start pushes a
// reference-model result onto a scoreboard queue. A monitor pops and compares
// it when done pulses, and also checks the 33-edge latency.
// -----------------------------------------------------------------------------
module tb_positdiv_iter;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic [31:0] in1     = '0;
    logic [31:0] in2     = '0;
    logic        busy;
    logic [31:0] result;
    logic        inf;
    logic        zero;
    logic        done;

    positdiv_iter #(.NBITS(32), .ES(2), .QBITS(31)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .in1    (in1),
        .in2    (in2),
        .busy   (busy),
        .result (result),
        .inf    (inf),
        .zero   (zero),
        .done   (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        inf;
        logic        zero;
        int          st_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Reference decode: walk the bits of the magnitude one at a time.
    function automatic void ref_decode(input logic [31:0] p, output int sc, output longint m);
        logic [31:0] mg;
        int          i;
        int          run;
        int          k;
        int          e;
        logic        r0;
        mg  = p[31] ? -p : p;
        i   = 30;
        r0  = mg[30];
        run = 0;
        while (i >= 0 && mg[i] == r0) begin
            run++;
            i--;
        end
        k = r0 ? run - 1 : -run;
        i--;
        e = 0;
        repeat (2) begin
            e = e * 2 + ((i >= 0) ? int'(mg[i]) : 0);
            i--;
        end
        m = 1;
        repeat (27) begin
            m = m * 2 + ((i >= 0) ? longint'(mg[i]) : 0);
            i--;
        end
        sc = 4 * k + e;
    endfunction

    // Reference divide: wide integer quotient, bit-serial posit string, RNE.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic inf_o,
                                    output logic zero_o);
        int           sa, sb, sc, e, k, n;
        longint       ma, mb, num, q, r, mag;
        logic [127:0] v;
        logic         guard, st;
        if (a == 32'h80000000 || b == 32'h80000000 || b == 32'h0) begin
            res = 32'h80000000; inf_o = 1'b1; zero_o = 1'b0;
            return;
        end
        if (a == 32'h0) begin
            res = 32'h0; inf_o = 1'b0; zero_o = 1'b1;
            return;
        end
        inf_o  = 1'b0;
        zero_o = 1'b0;
        ref_decode(a, sa, ma);
        ref_decode(b, sb, mb);
        num = ma << 34;
        q   = num / mb;
        r   = num % mb;
        sc  = sa - sb;
        if (q < (longint'(1) << 34)) begin
            q  = q << 1;
            sc = sc - 1;
        end
        if (sc > 120) begin
            mag = 64'h7FFFFFFF;
        end else if (sc < -120) begin
            mag = 64'h1;
        end else begin
            e = sc & 3;
            k = (sc - e) / 4;
            v = '0;
            n = 0;
            if (k >= 0) begin
                for (int i = 0; i <= k; i++) begin v = {v[126:0], 1'b1}; n++; end
                v = {v[126:0], 1'b0}; n++;
            end else begin
                for (int i = 0; i < -k; i++) begin v = {v[126:0], 1'b0}; n++; end
                v = {v[126:0], 1'b1}; n++;
            end
            v = {v[126:0], e[1]};
            v = {v[126:0], e[0]};
            n += 2;
            for (int i = 33; i >= 0; i--) begin v = {v[126:0], q[i]}; n++; end
            v     = v << (128 - n);
            mag   = longint'(v[127:97]);
            guard = v[96];
            st    = (r != 0) || (v[95:0] != '0);
            if (guard && (st || mag[0])) mag++;
            if (mag > 64'h7FFFFFFF) mag = 64'h7FFFFFFF;
        end
        res = (a[31] ^ b[31]) ? 32'(-mag) : 32'(mag);
    endfunction

    function automatic logic [31:0] rnd_posit();
        logic [31:0] x;
        int          r;
        x = $urandom;
        r = $urandom_range(0, 30);
        case ($urandom_range(0, 3))
            1:       x = {x[31], x[30:0] >> r};
            2:       x = {x[31], x[30:0] | ~(31'h7FFFFFFF >> r)};
            default: ;
        endcase
        return x;
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit push);
        exp_t e;
        @(posedge clk);
        #1;
        in1   = a;
        in2   = b;
        start = 1'b1;
        if (push) begin
            ref_div(a, b, e.res, e.inf, e.zero);
            e.a      = a;
            e.b      = b;
            e.st_cyc = cyc + 1;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int bcnt);
        bit got;
        got  = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check32("done_within_bound", 32'(got), 32'd1);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        int bc;
        start_op(a, b, 1'b1);
        wait_done(bc);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            tests++;
            assert (sb_q.size() > 0) else begin
                fails++;
                $error("FAIL unexpected_done observed=done expected=no_done result=%h", result);
            end
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                $display("[TB] %h / %h -> result=%h inf=%b zero=%b latency=%0d",
                         e.a, e.b, result, inf, zero, cyc - e.st_cyc);
                check32($sformatf("result %h/%h", e.a, e.b), result, e.res);
                check32($sformatf("inf %h/%h", e.a, e.b), 32'(inf), 32'(e.inf));
                check32($sformatf("zero %h/%h", e.a, e.b), 32'(zero), 32'(e.zero));
                check32($sformatf("latency %h/%h", e.a, e.b), 32'(cyc - e.st_cyc), 32'd33);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          bcnt;
        int          dcnt;
        logic [31:0] a;
        logic [31:0] b;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check32("reset_result", result, 32'h0);
        check32("reset_inf", 32'(inf), 32'd0);
        check32("reset_zero", 32'(zero), 32'd0);
        check32("reset_done", 32'(done), 32'd0);
        check32("reset_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;

        // 1/1 with busy-width check
        start_op(32'h40000000, 32'h40000000, 1'b1);
        wait_done(bcnt);
        check32("busy_cycles", 32'(bcnt), 32'd32);

        // Directed values and special cases
        run_op(32'h40000000, 32'h48000000);
        run_op(32'h4C000000, 32'h4C000000);
        run_op(32'hB8000000, 32'h40000000);
        run_op(32'h40000000, 32'h00000000);
        run_op(32'h00000000, 32'h48000000);
        run_op(32'h80000000, 32'h40000000);
        run_op(32'h7FFFFFFF, 32'h00000001);
        run_op(32'h00000001, 32'h7FFFFFFF);
        run_op(32'h40000000, 32'h4C000000);

        // Starts during an operation are ignored
        start_op(32'h4C000000, 32'h4C000000, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        in1   = 32'h48000000;
        in2   = 32'h40000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check32("busy_mid_op", 32'(busy), 32'd1);
        repeat (13) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(bcnt);
        repeat (3) @(negedge clk);
        check32("result_hold", result, 32'h40000000);
        check32("done_pulse_width", 32'(done), 32'd0);

        // Reset in the middle of an operation
        start_op(32'h40000000, 32'h48000000, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check32("abort_result", result, 32'h0);
        check32("abort_busy", 32'(busy), 32'd0);
        check32("abort_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check32("abort_no_done", 32'(dcnt), 32'd0);
        check32("abort_idle", 32'(busy), 32'd0);

        // Back-to-back: start held from the OUT cycle, accepted one cycle later
        start_op(32'h7FFFFFFF, 32'h00000001, 1'b1);
        repeat (32) @(posedge clk);
        #1;
        begin
            exp_t e2;
            in1   = 32'h00000001;
            in2   = 32'h7FFFFFFF;
            start = 1'b1;
            ref_div(in1, in2, e2.res, e2.inf, e2.zero);
            e2.a      = in1;
            e2.b      = in2;
            e2.st_cyc = cyc + 2;
            sb_q.push_back(e2);
        end
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(bcnt);

        // Random operands against the reference model
        for (int i = 0; i < 1000; i++) begin
            a = rnd_posit();
            b = rnd_posit();
            case ($urandom_range(0, 19))
                0:       a = 32'h0;
                1:       b = 32'h0;
                2:       a = 32'h80000000;
                3:       b = 32'h80000000;
                4:       b = a;
                default: ;
            endcase
            run_op(a, b);
        end

        repeat (5) @(negedge clk);
        check32("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
